// File: rtl/countdown_timer.sv
// Loadable down-counter timer with run/pause/expire control, advanced by an external
// tick strobe. State updates on the falling edge of NEclk; the reset is asynchronous.
//
// state   | meaning
// IDLE    | loaded or reset, not counting
// RUN     | decrementing once per Tick
// PAUSED  | counting suspended, count held
// EXPIRED | reached zero without reload, count held at 0
module countdown_timer #(
    parameter int BITS        = 4,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic            NEclk,
    input  logic            Nreset,
    input  logic            Load,
    input  logic [BITS-1:0] Preset,
    input  logic            Start,
    input  logic            Stop,
    input  logic            Tick,
    output logic [BITS-1:0] count,
    output logic            Running,
    output logic            Expired,
    output logic            Done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    localparam logic [BITS-1:0] ONE = {{(BITS-1){1'b0}}, 1'b1};

    state_t          state, state_nx;
    logic [BITS-1:0] count_nx;
    logic            done_nx;
    logic            preset_zero;

    assign preset_zero = (Preset == '0);

    always_ff @(negedge NEclk or negedge Nreset) begin
        if (!Nreset) begin
            state <= IDLE;
            count <= '0;
            Done  <= 1'b0;
        end else begin
            state <= state_nx;
            count <= count_nx;
            Done  <= done_nx;
        end
    end

    always_comb begin
        state_nx = state;
        count_nx = count;
        done_nx  = 1'b0;
        unique case (state)
            IDLE: begin
                if (Load) begin
                    count_nx = Preset;
                end else if (Start && count != '0) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (Load) begin
                    count_nx = Preset;
                    if (preset_zero) state_nx = IDLE;
                end else if (Stop) begin
                    state_nx = PAUSED;
                end else if (Tick) begin
                    if (count > ONE) begin
                        count_nx = count - ONE;
                    end else if (count == ONE) begin
                        done_nx = 1'b1;
                        if (AUTO_RELOAD && !preset_zero) begin
                            count_nx = Preset;
                        end else begin
                            count_nx = '0;
                            state_nx = EXPIRED;
                        end
                    end
                end
            end
            PAUSED: begin
                if (Load) begin
                    count_nx = Preset;
                    state_nx = IDLE;
                end else if (Start) begin
                    state_nx = RUN;
                end
            end
            EXPIRED: begin
                // Start restarts from Preset; a zero Preset leaves nothing to count
                if (Load) begin
                    count_nx = Preset;
                    state_nx = IDLE;
                end else if (Start) begin
                    count_nx = Preset;
                    if (!preset_zero) state_nx = RUN;
                end
            end
            default: begin
                state_nx = IDLE;
                count_nx = '0;
            end
        endcase
    end

    assign Running = (state == RUN);
    assign Expired = (state == EXPIRED);

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench: two timers (stop-at-zero and auto-reload) share stimulus; a
// behavioural model queues expected outputs and a monitor compares each falling edge.
module tb_countdown_timer;

    localparam int BITS = 4;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;

    logic            NEclk = 1'b1;
    logic            Nreset;
    logic            Load, Start, Stop, Tick;
    logic [BITS-1:0] Preset;
    logic [BITS-1:0] count0, count1;
    logic            run0, exp0, done0, run1, exp1, done1;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [BITS-1:0] c;
        logic            r;
        logic            e;
        logic            d;
    } obs_t;

    typedef struct packed {
        obs_t a;
        obs_t b;
    } exp_t;

    exp_t sb_q[$];

    int m_cnt[2];
    int m_mode[2];

    always #5 NEclk = ~NEclk;

    countdown_timer #(.BITS(BITS), .AUTO_RELOAD(1'b0)) dut0 (
        .NEclk(NEclk), .Nreset(Nreset), .Load(Load), .Preset(Preset),
        .Start(Start), .Stop(Stop), .Tick(Tick),
        .count(count0), .Running(run0), .Expired(exp0), .Done(done0)
    );

    countdown_timer #(.BITS(BITS), .AUTO_RELOAD(1'b1)) dut1 (
        .NEclk(NEclk), .Nreset(Nreset), .Load(Load), .Preset(Preset),
        .Start(Start), .Stop(Stop), .Tick(Tick),
        .count(count1), .Running(run1), .Expired(exp1), .Done(done1)
    );

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Behavioural model: the timer's rules applied to an integer count and a mode.
    task automatic model_step(input int idx, input bit ar, output bit dn);
        int pre;
        pre = int'(Preset);
        dn  = 1'b0;
        if (m_mode[idx] == M_IDLE) begin
            if (Load) m_cnt[idx] = pre;
            else if (Start && m_cnt[idx] > 0) m_mode[idx] = M_RUN;
        end else if (m_mode[idx] == M_RUN) begin
            if (Load) begin
                m_cnt[idx] = pre;
                if (pre == 0) m_mode[idx] = M_IDLE;
            end else if (Stop) begin
                m_mode[idx] = M_PAUSE;
            end else if (Tick && m_cnt[idx] > 0) begin
                m_cnt[idx] = m_cnt[idx] - 1;
                if (m_cnt[idx] == 0) begin
                    dn = 1'b1;
                    if (ar && pre != 0) m_cnt[idx] = pre;
                    else m_mode[idx] = M_EXP;
                end
            end
        end else if (m_mode[idx] == M_PAUSE) begin
            if (Load) begin
                m_cnt[idx] = pre;
                m_mode[idx] = M_IDLE;
            end else if (Start) begin
                m_mode[idx] = M_RUN;
            end
        end else begin
            if (Load) begin
                m_cnt[idx] = pre;
                m_mode[idx] = M_IDLE;
            end else if (Start) begin
                m_cnt[idx] = pre;
                if (pre != 0) m_mode[idx] = M_RUN;
            end
        end
    endtask

    function automatic obs_t pack_obs(input int idx, input bit dn);
        obs_t o;
        o.c = BITS'(m_cnt[idx]);
        o.r = (m_mode[idx] == M_RUN);
        o.e = (m_mode[idx] == M_EXP);
        o.d = dn;
        return o;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i]  = 0;
            m_mode[i] = M_IDLE;
        end
    endtask

    // Drive one cycle: inputs change mid-period, the falling edge samples them.
    task automatic step(input bit ld, input int pre, input bit st, input bit sp, input bit tk);
        bit   d0, d1;
        exp_t e;
        @(posedge NEclk);
        Load   = ld;
        Preset = BITS'(pre);
        Start  = st;
        Stop   = sp;
        Tick   = tk;
        model_step(0, 1'b0, d0);
        model_step(1, 1'b1, d1);
        e.a = pack_obs(0, d0);
        e.b = pack_obs(1, d1);
        sb_q.push_back(e);
        @(negedge NEclk);
    endtask

    always @(negedge NEclk) begin
        #1;
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check("timer_stop", int'({count0, run0, exp0, done0}), int'(e.a));
            check("timer_reload", int'({count1, run1, exp1, done1}), int'(e.b));
        end
    end

    initial begin
        Nreset = 1'b0;
        Load = 0; Start = 0; Stop = 0; Tick = 0; Preset = '0;
        model_reset();
        #3;
        check("reset_count", int'(count0), 0);
        check("reset_flags", int'({run0, exp0, done0, run1, exp1, done1}), 0);
        @(posedge NEclk);
        Nreset = 1'b1;

        // T1: async reset while running with count=5
        step(1, 5, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        #2;
        Nreset = 1'b0;
        #1;
        check("t1_count_async", int'(count0), 0);
        check("t1_running_async", int'(run0), 0);
        @(negedge NEclk);
        #1;
        check("t1_no_done", int'({done0, done1}), 0);
        @(posedge NEclk);
        Nreset = 1'b1;
        model_reset();

        // T6a: Start with count=0 stays idle
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1);

        // T2: Preset 3, Start, 3 Ticks, then extra Ticks
        step(1, 3, 0, 0, 0);
        step(0, 3, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 3, 0, 0, 1);

        // T3: count 6, Stop with Tick, ignored Ticks, Start with Tick, Tick
        step(1, 6, 0, 0, 0);
        step(0, 6, 1, 0, 0);
        step(0, 6, 0, 1, 1);
        step(0, 6, 0, 0, 1);
        step(0, 6, 1, 0, 1);
        step(0, 6, 0, 0, 1);

        // T4: Load/Stop/Tick together in RUN
        step(0, 6, 0, 0, 1);
        step(1, 9, 0, 1, 1);
        step(0, 9, 0, 0, 1);

        // T5: Preset 2 auto-reload run; stop-at-zero instance expires
        step(1, 2, 0, 0, 0);
        step(0, 2, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 2, 0, 0, 1);
        step(0, 2, 1, 0, 0);

        // T6b: Preset 15 counts down fully, then restart from EXPIRED
        step(1, 15, 0, 0, 0);
        step(0, 15, 1, 0, 0);
        for (int i = 0; i < 16; i++) step(0, 15, 0, 0, 1);
        step(0, 0, 1, 0, 0);
        step(0, 4, 1, 0, 0);
        step(1, 0, 0, 0, 0);

        // randomized traffic, biased toward ticks
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) < 8, $urandom_range(0, 15),
                 $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 8,
                 $urandom_range(0, 99) < 60);
        end

        @(negedge NEclk);
        #2;
        check("scoreboard_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
